// File: rtl/id_ex_decode_issue_pkg.sv
// Shared definitions for the ID-stage decoder and the ID/EX issue register:
// MIPS opcode/funct encodings, ALUControl codes and the control bundle layout.
package id_ex_decode_issue_pkg;

  localparam int INSTR_W = 32;
  localparam int REG_W   = 5;
  localparam int ALUC_W  = 3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  localparam logic [ALUC_W-1:0] ALU_AND  = 3'b000;
  localparam logic [ALUC_W-1:0] ALU_OR   = 3'b001;
  localparam logic [ALUC_W-1:0] ALU_ADDU = 3'b010;
  localparam logic [ALUC_W-1:0] ALU_SUBU = 3'b110;
  localparam logic [ALUC_W-1:0] ALU_SLT  = 3'b111;

  typedef struct packed {
    logic [ALUC_W-1:0]  alu_control;
    logic               alu_src_imm;
    logic               a_zero;
    logic [INSTR_W-1:0] imm;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   wreg;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic               illegal;
    logic               reads_rt;
  } ctrl_t;

endpackage

// File: rtl/id_ex_decode_issue_mips_ctrl_decode.sv
// Pure combinational MIPS instruction decoder producing the EX-stage control
// bundle, including whether the instruction reads rt (for hazard detection).
module mips_ctrl_decode
  import id_ex_decode_issue_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output ctrl_t              ctrl
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [INSTR_W-1:0] imm_sext;
  logic [INSTR_W-1:0] imm_zext;

  assign op       = instr[31:26];
  assign funct    = instr[5:0];
  assign imm16    = instr[15:0];
  assign imm_sext = {{16{imm16[15]}}, imm16};
  assign imm_zext = {16'h0000, imm16};

  always_comb begin
    ctrl         = '0;
    ctrl.rs      = instr[25:21];
    ctrl.rt      = instr[20:16];
    ctrl.illegal = 1'b1;
    if (instr == '0) begin
      ctrl.illegal = 1'b0;
    end else begin
      unique case (op)
        OP_RTYPE: begin
          ctrl.illegal   = 1'b0;
          ctrl.reg_write = 1'b1;
          ctrl.wreg      = instr[15:11];
          ctrl.reads_rt  = 1'b1;
          unique case (funct)
            FN_ADDU: ctrl.alu_control = ALU_ADDU;
            FN_SUBU: ctrl.alu_control = ALU_SUBU;
            FN_AND:  ctrl.alu_control = ALU_AND;
            FN_OR:   ctrl.alu_control = ALU_OR;
            FN_SLT:  ctrl.alu_control = ALU_SLT;
            default: begin
              ctrl.illegal   = 1'b1;
              ctrl.reg_write = 1'b0;
              ctrl.wreg      = '0;
              ctrl.reads_rt  = 1'b0;
            end
          endcase
        end
        OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI, OP_LW: begin
          ctrl.illegal     = 1'b0;
          ctrl.reg_write   = 1'b1;
          ctrl.wreg        = instr[20:16];
          ctrl.alu_src_imm = 1'b1;
          ctrl.alu_control = ALU_ADDU;
          ctrl.imm         = imm_sext;
          if (op == OP_ANDI) begin
            ctrl.alu_control = ALU_AND;
            ctrl.imm         = imm_zext;
          end else if (op == OP_ORI) begin
            ctrl.alu_control = ALU_OR;
            ctrl.imm         = imm_zext;
          end else if (op == OP_LUI) begin
            ctrl.alu_control = ALU_OR;
            ctrl.a_zero      = 1'b1;
            ctrl.imm         = {imm16, 16'h0000};
          end else if (op == OP_LW) begin
            ctrl.mem_read    = 1'b1;
          end
        end
        OP_SW: begin
          ctrl.illegal     = 1'b0;
          ctrl.wreg        = instr[20:16];
          ctrl.alu_src_imm = 1'b1;
          ctrl.alu_control = ALU_ADDU;
          ctrl.imm         = imm_sext;
          ctrl.mem_write   = 1'b1;
          ctrl.reads_rt    = 1'b1;
        end
        OP_BEQ: begin
          ctrl.illegal     = 1'b0;
          ctrl.wreg        = instr[20:16];
          ctrl.alu_control = ALU_SUBU;
          ctrl.imm         = {imm_sext[29:0], 2'b00};
          ctrl.branch      = 1'b1;
          ctrl.reads_rt    = 1'b1;
        end
        default: ;
      endcase
    end
    // Writes to $0 are architecturally discarded; suppress them here.
    if (ctrl.wreg == '0) ctrl.reg_write = 1'b0;
  end

endmodule

// File: rtl/id_ex_decode_issue.sv
// ID/EX issue register: decodes one instruction per cycle, handles the IF/ID
// handshake, inserts a single bubble on load-use, and honours stall/flush.
module id_ex_decode_issue
  import id_ex_decode_issue_pkg::*;
#(
  parameter bit LOAD_USE_CHECK = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  input  logic [INSTR_W-1:0] pc,
  input  logic               ex_stall,
  input  logic               flush,
  output logic               instr_ready,
  output logic               ex_valid,
  output logic [ALUC_W-1:0]  ex_alu_control,
  output logic               ex_alu_src_imm,
  output logic               ex_a_zero,
  output logic [INSTR_W-1:0] ex_imm,
  output logic [REG_W-1:0]   ex_rs,
  output logic [REG_W-1:0]   ex_rt,
  output logic [REG_W-1:0]   ex_wreg,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_branch,
  output logic               ex_illegal,
  output logic [INSTR_W-1:0] ex_pc
);

  ctrl_t              dec_p0;
  ctrl_t              ctrl_p1;
  logic               vld_p1;
  logic [INSTR_W-1:0] pc_p1;
  logic               load_use;

  mips_ctrl_decode u_decode (
    .instr (instr),
    .ctrl  (dec_p0)
  );

  assign load_use = LOAD_USE_CHECK && instr_valid && vld_p1 && ctrl_p1.mem_read
                    && (ctrl_p1.wreg != '0)
                    && ((dec_p0.rs == ctrl_p1.wreg)
                        || (dec_p0.reads_rt && (dec_p0.rt == ctrl_p1.wreg)));

  assign instr_ready = flush || (!ex_stall && !load_use);

  // ID -> EX register boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
      pc_p1   <= '0;
    end else if (flush || (!ex_stall && (load_use || !instr_valid))) begin
      vld_p1            <= 1'b0;
      ctrl_p1.reg_write <= 1'b0;
      ctrl_p1.mem_read  <= 1'b0;
      ctrl_p1.mem_write <= 1'b0;
      ctrl_p1.branch    <= 1'b0;
      ctrl_p1.illegal   <= 1'b0;
    end else if (!ex_stall) begin
      vld_p1  <= 1'b1;
      ctrl_p1 <= dec_p0;
      pc_p1   <= pc;
    end
  end

  assign ex_valid       = vld_p1;
  assign ex_alu_control = ctrl_p1.alu_control;
  assign ex_alu_src_imm = ctrl_p1.alu_src_imm;
  assign ex_a_zero      = ctrl_p1.a_zero;
  assign ex_imm         = ctrl_p1.imm;
  assign ex_rs          = ctrl_p1.rs;
  assign ex_rt          = ctrl_p1.rt;
  assign ex_wreg        = ctrl_p1.wreg;
  assign ex_reg_write   = ctrl_p1.reg_write;
  assign ex_mem_read    = ctrl_p1.mem_read;
  assign ex_mem_write   = ctrl_p1.mem_write;
  assign ex_branch      = ctrl_p1.branch;
  assign ex_illegal     = ctrl_p1.illegal;
  assign ex_pc          = pc_p1;

  // reads_rt is consumed only from the decoder side; keep the registered copy referenced.
  logic unused_p1;
  assign unused_p1 = ctrl_p1.reads_rt;

endmodule
